npu_banked_ram: RTL and testbench
=================================

# npu_banked_ram

Parametrised banked single-port RAM for NPU weight/activation memories: a generation beyond the fixed two-bank 512x8 part. It decodes a memory-select field, splits the register address into bank index and row, and drives `NBANK` synchronous single-port bank macros. It adds a registered read-valid handshake, an output hold register, out-of-range/busy error flagging and a hardware clear engine that zeroes the whole memory. It sits on the NPU memory bus between the AHB-side address decoder and the datapath.

## Interface
- `WIDTH`, 8: data width in bits.
- `NBANK`, 2: number of banks; power of two, ≥1.
- `BANK_DEPTH`, 256: rows per bank; power of two.
- `MEMSEL_W`, 6: width of memory-select field.
- `REGSEL_W`, 9: width of register address; ≥ log2(NBANK*BANK_DEPTH).
- `MEM_ADDR`, 6'b000010: `mem_adr` value that selects this memory.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_adr` in MEMSEL_W: memory select.
- `reg_adr` in REGSEL_W: word address; `[log2(BANK_DEPTH)-1:0]` = row, the next log2(NBANK) bits = bank, any bits above that are out-of-range bits.
- `en` in 1: access request, one per cycle.
- `we` in 1: 1 = write, 0 = read (qualified by `en`).
- `din` in WIDTH: write data.
- `clr` in 1: start clear, pulse or level; sampled only in IDLE.
- `dout` out WIDTH: read data, held between reads.
- `rvalid` out 1: one-cycle pulse, `dout` carries new read data.
- `busy` out 1: clear engine active.
- `err` out 1: one-cycle pulse, request rejected.

## Operation
- Hit = `en & (mem_adr == MEM_ADDR)`. Reads and writes both require a hit. A non-hit does nothing and is not an error.
- Out-of-range: any `reg_adr` bit above the bank field is set. On a hit, the access is dropped and `err` pulses next cycle. For a read, `rvalid` stays 0 and `dout` is unchanged.
- Write hit: only the addressed bank is enabled, at the addressed row with `din`. No `rvalid`.
- Read hit: only the addressed bank is enabled. The bank index is registered and selects the bank output next cycle. `dout` updates and `rvalid` pulses.
- `dout` is a hold register loaded only when `rvalid` is asserted. Writes, idle cycles and clear never change `dout`.
- FSM states: IDLE, CLEAR.
  - IDLE→CLEAR when `clr=1`. The row counter loads 0 and `busy` rises next cycle.
  - In CLEAR, every cycle all banks write 0 at the counter row and the counter increments.
  - CLEAR→IDLE after row `BANK_DEPTH-1` is written. The counter does not wrap.
- Any hit during CLEAR is ignored and `err` pulses next cycle. `clr` during CLEAR is ignored.
- `clr` and a hit in the same IDLE cycle: the hit completes normally and CLEAR starts the same edge. The hit's bank access wins on that edge and clearing begins at row 0 on the following cycle.

## Timing
- Reset values: `dout`=0, `rvalid`=0, `busy`=0, `err`=0, FSM=IDLE, counter=0.
- Read latency 1: request at edge N, data and `rvalid` valid after edge N+1.
- Back-to-back reads to different banks are supported at one per cycle.
- Write followed next cycle by a read to the same address returns the new data.
- Clear takes exactly `BANK_DEPTH` cycles with `busy`=1. Accesses are accepted again on the cycle `busy` falls.
- Reset asserted mid-clear: FSM returns to IDLE immediately. Memory contents are then undefined; software must re-issue `clr`.
- Reset asserted mid-read: the pending `rvalid` is cancelled.

## Structure
- Package `npu_mem_pkg` holds:
  - the FSM enum `npu_mem_state_t` {IDLE, CLEAR};
  - the localparam helpers for bank/row field widths (derived from `NBANK` and `BANK_DEPTH` via `$clog2`).
- Sub-module `npu_sram_sp` (ports Q, CLK, CEN active-low, WEN active-low, A, D):
  - a behavioural synchronous single-port bank;
  - Q holds when CEN is high;
  - it is swapped for a vendor macro under `HAPS`/ASIC defines.
- Instantiate `NBANK` copies with a generate loop. The clear engine drives all banks' CEN/WEN/A/D through a mux in front of them.

## Test plan
- Default params, write 0xA5 to `reg_adr` 0x003 (bank 0) and 0x5A to 0x103 (bank 1), then read both back-to-back → `dout`=0xA5 then 0x5A on consecutive cycles, `rvalid` high for both.
- Read with `mem_adr`=0x01 → no `rvalid`, no `err`, `dout` retains the previous 0x5A.
- Out of range: `NBANK`=2, `BANK_DEPTH`=128, `REGSEL_W`=9, read `reg_adr`=0x100 → `err` pulses for 1 cycle, `rvalid`=0, `dout` unchanged.
- Fill the memory with 0xFF, pulse `clr` → `busy` high for exactly 256 cycles. A hit issued mid-clear gives an `err` pulse. Afterwards every address reads 0x00.
- Pulse `clr` together with a read of 0x010 → the read returns pre-clear data with `rvalid`, then `busy` rises.
- Assert `rst_n`=0 at clear row 100 → `busy`, `rvalid`, `err` and `dout` go to 0 asynchronously, FSM is IDLE. A new `clr` then completes a full 256-cycle pass.

Source files
------------

// File: rtl/npu_mem_pkg.sv
// Shared types and field-width helpers for the banked NPU memory.
// Synthesises to no logic; the helpers are evaluated at elaboration time only.
package npu_mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } npu_mem_state_t;

  // Row field width; a single-row bank still needs one address bit on the macro.
  function automatic int row_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Number of reg_adr bits consumed by the bank index (0 for a single bank).
  function automatic int bank_bits(input int nbank);
    return (nbank > 1) ? $clog2(nbank) : 0;
  endfunction

  // Width of the registered bank index, kept at least one bit wide.
  function automatic int bank_idx_w(input int nbank);
    return (nbank > 1) ? $clog2(nbank) : 1;
  endfunction

endpackage

// File: rtl/npu_sram_sp.sv
// Behavioural synchronous single-port bank: 1-cycle read, Q holds while CEN is high.
// No backpressure; HAPS/ASIC builds compile a vendor macro wrapper of the same name instead.
`ifndef HAPS
`ifndef ASIC
module npu_sram_sp #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  output logic [WIDTH-1:0] Q,
  input  logic             CLK,
  input  logic             CEN,
  input  logic             WEN,
  input  logic [AW-1:0]    A,
  input  logic [WIDTH-1:0] D
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write cycles leave Q untouched, matching the macro's read-only output latch.
  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!WEN) mem[A] <= D;
      else      Q      <= mem[A];
    end
  end

endmodule
`endif
`endif

// File: rtl/npu_banked_ram.sv
// Banked single-port RAM with memory-select decode, 1-cycle registered read (rvalid), held dout.
// No backpressure: accesses during the BANK_DEPTH-cycle clear pass, or out of range, are dropped with err.
module npu_banked_ram
  import npu_mem_pkg::*;
#(
  parameter int                  WIDTH      = 8,
  parameter int                  NBANK      = 2,
  parameter int                  BANK_DEPTH = 256,
  parameter int                  MEMSEL_W   = 6,
  parameter int                  REGSEL_W   = 9,
  parameter logic [MEMSEL_W-1:0] MEM_ADDR   = 6'b000010
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [MEMSEL_W-1:0] mem_adr,
  input  logic [REGSEL_W-1:0] reg_adr,
  input  logic                en,
  input  logic                we,
  input  logic [WIDTH-1:0]    din,
  input  logic                clr,
  output logic [WIDTH-1:0]    dout,
  output logic                rvalid,
  output logic                busy,
  output logic                err
);

  localparam int ROW_W     = row_w(BANK_DEPTH);
  localparam int BANK_BITS = bank_bits(NBANK);
  localparam int BANK_W    = bank_idx_w(NBANK);
  localparam int FIELD_W   = ROW_W + BANK_BITS;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BANK_DEPTH - 1);

  npu_mem_state_t   state;
  logic [ROW_W-1:0] clr_row;
  logic [ROW_W-1:0] row;
  logic [BANK_W-1:0] bank;
  logic [BANK_W-1:0] rd_bank;
  logic             rd_pend;
  logic             oor;
  logic             hit;
  logic             acc;
  logic [WIDTH-1:0] q [NBANK];

  assign row = reg_adr[ROW_W-1:0];

  generate
    if (NBANK > 1) begin : g_bank_field
      assign bank = reg_adr[ROW_W +: BANK_BITS];
    end else begin : g_single_bank
      assign bank = '0;
    end

    if (REGSEL_W > FIELD_W) begin : g_oor
      assign oor = |reg_adr[REGSEL_W-1:FIELD_W];
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
  endgenerate

  assign hit = en & (mem_adr == MEM_ADDR);
  assign acc = hit & ~oor & (state == IDLE);

  // While clearing, every bank is forced to write zero at the shared row counter.
  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic             cen;
    logic             wen;
    logic [ROW_W-1:0] a;
    logic [WIDTH-1:0] d;

    always_comb begin
      cen = 1'b1;
      wen = 1'b1;
      a   = row;
      d   = din;
      if (state == CLEAR) begin
        cen = 1'b0;
        wen = 1'b0;
        a   = clr_row;
        d   = '0;
      end else if (acc && (bank == BANK_W'(b))) begin
        cen = 1'b0;
        wen = ~we;
      end
    end

    npu_sram_sp #(
      .WIDTH (WIDTH),
      .DEPTH (BANK_DEPTH),
      .AW    (ROW_W)
    ) u_sram (
      .Q   (q[b]),
      .CLK (clk),
      .CEN (cen),
      .WEN (wen),
      .A   (a),
      .D   (d)
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clr_row <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
      rd_pend <= 1'b0;
      rd_bank <= '0;
      rvalid  <= 1'b0;
      dout    <= '0;
    end else begin
      err     <= hit & (oor | (state == CLEAR));
      rd_pend <= acc & ~we;
      rvalid  <= rd_pend;
      if (acc) rd_bank <= bank;
      if (rd_pend) dout <= q[rd_bank];

      case (state)
        IDLE: begin
          if (clr) begin
            state   <= CLEAR;
            clr_row <= '0;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          // Counter parks on the last row rather than wrapping.
          if (clr_row == LAST_ROW) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            clr_row <= clr_row + ROW_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_banked_ram.sv
// Randomised bench for npu_banked_ram against a flat-address-space reference model.
module tb_npu_banked_ram;

  localparam int          DEPTH  = 256;
  localparam int          NWORDS = 512;
  localparam logic [5:0]  SEL    = 6'b000010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] mem_adr;
  logic [8:0] reg_adr;
  logic       en, we, clr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       rvalid, busy, err;

  logic [5:0] b_mem_adr;
  logic [8:0] b_reg_adr;
  logic       b_en, b_we, b_clr;
  logic [7:0] b_din;
  logic [7:0] b_dout;
  logic       b_rvalid, b_busy, b_err;

  always #5 clk = ~clk;

  npu_banked_ram u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mem_adr (mem_adr),
    .reg_adr (reg_adr),
    .en      (en),
    .we      (we),
    .din     (din),
    .clr     (clr),
    .dout    (dout),
    .rvalid  (rvalid),
    .busy    (busy),
    .err     (err)
  );

  npu_banked_ram #(.BANK_DEPTH(128)) u_dut_small (
    .clk     (clk),
    .rst_n   (rst_n),
    .mem_adr (b_mem_adr),
    .reg_adr (b_reg_adr),
    .en      (b_en),
    .we      (b_we),
    .din     (b_din),
    .clr     (b_clr),
    .dout    (b_dout),
    .rvalid  (b_rvalid),
    .busy    (b_busy),
    .err     (b_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: memory is one flat array indexed by reg_adr; a clear
  // pass is a count of remaining rows, each zeroing that row in every bank.
  logic [7:0] m_mem [NWORDS];
  int         m_left;
  bit         m_pend;
  logic [7:0] m_pend_data;
  logic [7:0] m_dout;

  task automatic model_reset();
    m_left = 0;
    m_pend = 1'b0;
    m_dout = 8'h00;
  endtask

  task automatic step(input bit e, input bit w, input logic [5:0] ma,
                      input logic [8:0] ra, input logic [7:0] d, input bit c);
    bit         hit, clearing, rd;
    bit         exp_rv, exp_err, exp_busy;
    int         row;
    en = e; we = w; mem_adr = ma; reg_adr = ra; din = d; clr = c;
    hit      = e && (ma == SEL);
    clearing = (m_left > 0);
    exp_rv   = m_pend;
    if (m_pend) m_dout = m_pend_data;
    exp_err  = hit && clearing;
    rd       = hit && !clearing && !w;
    m_pend   = rd;
    if (rd) m_pend_data = m_mem[ra];
    if (hit && !clearing && w) m_mem[ra] = d;
    if (clearing) begin
      row = DEPTH - m_left;
      m_mem[row]         = 8'h00;
      m_mem[DEPTH + row] = 8'h00;
      m_left--;
    end else if (c) begin
      m_left = DEPTH;
    end
    exp_busy = (m_left > 0);
    @(posedge clk);
    #1;
    check_val("rvalid", rvalid, exp_rv);
    check_val("err", err, exp_err);
    check_val("busy", busy, exp_busy);
    check_val("dout", dout, m_dout);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 6'h00, 9'h000, 8'h00, 1'b0);
  endtask

  // Starts a clear, counts busy cycles, optionally fires one read hit mid-pass.
  task automatic run_clear(input string tag, input int hit_at);
    int cnt;
    step(1'b0, 1'b0, 6'h00, 9'h000, 8'h00, 1'b1);
    cnt = 0;
    for (int k = 0; k < 400 && busy; k++) begin
      cnt++;
      if (cnt == hit_at) step(1'b1, 1'b0, SEL, 9'($urandom), 8'h00, 1'b0);
      else               idle();
    end
    check_val(tag, cnt, DEPTH);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400 && busy; k++) idle();
    check_val("busy_timeout", busy, 1'b0);
  endtask

  task automatic small_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 0; we = 0; clr = 0; mem_adr = 0; reg_adr = 0; din = 0;
    b_en = 0; b_we = 0; b_clr = 0; b_mem_adr = SEL; b_reg_adr = 0; b_din = 0;
    model_reset();
    for (int i = 0; i < NWORDS; i++) m_mem[i] = 8'h00;
    #12;
    check_val("rst_dout", dout, 8'h00);
    check_val("rst_rvalid", rvalid, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_err", err, 1'b0);
    check_val("rst_b_dout", b_dout, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_clear("init_clear_len", -1);

    // Two banks written then read back-to-back.
    step(1'b1, 1'b1, SEL, 9'h003, 8'hA5, 1'b0);
    step(1'b1, 1'b1, SEL, 9'h103, 8'h5A, 1'b0);
    step(1'b1, 1'b0, SEL, 9'h003, 8'h00, 1'b0);
    step(1'b1, 1'b0, SEL, 9'h103, 8'h00, 1'b0);
    check_val("tp_a5_dout", dout, 8'hA5);
    check_val("tp_a5_rvalid", rvalid, 1'b1);
    idle();
    check_val("tp_5a_dout", dout, 8'h5A);
    check_val("tp_5a_rvalid", rvalid, 1'b1);
    step(1'b1, 1'b0, 6'h01, 9'h003, 8'h00, 1'b0);
    idle();
    check_val("nohit_dout", dout, 8'h5A);
    check_val("nohit_rvalid", rvalid, 1'b0);

    // Write then immediate read of the same address.
    step(1'b1, 1'b1, SEL, 9'h0C7, 8'h3E, 1'b0);
    step(1'b1, 1'b0, SEL, 9'h0C7, 8'h00, 1'b0);
    idle();
    check_val("wr_rd_fwd", dout, 8'h3E);

    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom),
           1'($urandom),
           ($urandom_range(0, 9) < 8) ? SEL : 6'($urandom),
           9'($urandom),
           8'($urandom),
           ($urandom_range(0, 199) == 0));
    end
    wait_idle();

    // Fill with 0xFF, clear with a mid-pass hit, then every word must read 0.
    for (int a = 0; a < NWORDS; a++) step(1'b1, 1'b1, SEL, 9'(a), 8'hFF, 1'b0);
    step(1'b1, 1'b0, SEL, 9'h155, 8'h00, 1'b0);
    idle();
    check_val("fill_ff", dout, 8'hFF);
    run_clear("fill_clear_len", 50);
    for (int a = 0; a < NWORDS; a++) step(1'b1, 1'b0, SEL, 9'(a), 8'h00, 1'b0);
    idle();

    // Read and clr in the same cycle: read sees pre-clear data.
    step(1'b1, 1'b1, SEL, 9'h010, 8'h42, 1'b0);
    step(1'b1, 1'b0, SEL, 9'h010, 8'h00, 1'b1);
    idle();
    check_val("clr_rd_dout", dout, 8'h42);
    check_val("clr_rd_busy", busy, 1'b1);
    wait_idle();
    step(1'b1, 1'b0, SEL, 9'h010, 8'h00, 1'b0);
    idle();
    check_val("clr_rd_after", dout, 8'h00);

    // Reset at clear row 100.
    step(1'b1, 1'b1, SEL, 9'h020, 8'h99, 1'b0);
    step(1'b1, 1'b0, SEL, 9'h020, 8'h00, 1'b0);
    idle();
    step(1'b0, 1'b0, 6'h00, 9'h000, 8'h00, 1'b1);
    for (int k = 0; k < 99; k++) idle();
    step(1'b1, 1'b0, SEL, 9'h020, 8'h00, 1'b0);
    check_val("pre_rst_err", err, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_busy", busy, 1'b0);
    check_val("arst_rvalid", rvalid, 1'b0);
    check_val("arst_err", err, 1'b0);
    check_val("arst_dout", dout, 8'h00);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_clear("post_rst_clear_len", -1);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, SEL, 9'($urandom), 8'h00, 1'b0);
    idle();

    // Reset between a read request and its rvalid.
    step(1'b1, 1'b1, SEL, 9'h030, 8'h3C, 1'b0);
    step(1'b1, 1'b0, SEL, 9'h030, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rd_rvalid", rvalid, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    check_val("mid_rd_cancel", rvalid, 1'b0);
    step(1'b1, 1'b0, SEL, 9'h030, 8'h00, 1'b0);
    idle();
    check_val("mid_rd_mem_kept", dout, 8'h3C);

    // Out-of-range on the 2x128 instance: bit 8 is above the bank field.
    b_en = 1; b_we = 1; b_reg_adr = 9'h000; b_din = 8'h11;
    small_cycle();
    b_reg_adr = 9'h100; b_din = 8'h77;
    small_cycle();
    check_val("oor_wr_err", b_err, 1'b1);
    b_en = 0;
    small_cycle();
    check_val("oor_wr_err_clr", b_err, 1'b0);
    b_en = 1; b_we = 0; b_reg_adr = 9'h000;
    small_cycle();
    b_en = 0;
    small_cycle();
    check_val("oor_base_rvalid", b_rvalid, 1'b1);
    check_val("oor_base_dout", b_dout, 8'h11);
    b_en = 1; b_reg_adr = 9'h100;
    small_cycle();
    check_val("oor_rd_err", b_err, 1'b1);
    check_val("oor_rd_rvalid0", b_rvalid, 1'b0);
    b_en = 0;
    small_cycle();
    check_val("oor_rd_err_pulse", b_err, 1'b0);
    check_val("oor_rd_rvalid1", b_rvalid, 1'b0);
    check_val("oor_rd_dout", b_dout, 8'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
